// File: rtl/conv3x3_window_filter_if.sv
// Filtered-pixel output stream: one pixel per 3x3 window, tagged with the
// window's top-left coordinate, moved with a valid/ready handshake.
interface conv3x3_window_filter_if #(
    parameter int DIM_W = 16
);
    logic [7:0]       pix_out;
    logic [DIM_W-1:0] out_x;
    logic [DIM_W-1:0] out_y;
    logic             pix_valid;
    logic             pix_ready;

    modport master (
        output pix_out,
        output out_x,
        output out_y,
        output pix_valid,
        input  pix_ready
    );

    modport slave (
        input  pix_out,
        input  out_x,
        input  out_y,
        input  pix_valid,
        output pix_ready
    );
endinterface

// File: rtl/conv3x3_window_filter.sv
// Scans every full 3x3 window of a loaded frame buffer and emits one Gaussian or Sobel pixel per window.
// Latency: 9 issue cycles + RD_LAT+1 drain + 1 compute cycle per window; data0 is sampled RD_LAT+1 edges after its address.
// Backpressure: pix_ready low holds the output stable and stalls all further reads until the handshake.
module conv3x3_window_filter #(
    parameter int RD_LAT = 3,
    parameter int DIM_W  = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         mode,
    input  logic                         all_loaded,
    input  logic [DIM_W-1:0]             H,
    input  logic [DIM_W-1:0]             W,
    input  logic [7:0]                   data0,
    output logic [DIM_W-1:0]             read_H,
    output logic [DIM_W-1:0]             read_W,
    output logic                         busy,
    output logic                         done,
    conv3x3_window_filter_if.master      pix
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_OUTPUT,
        S_DONE
    } state_t;

    state_t             state;
    logic               mode_q;
    logic [DIM_W-1:0]   h_q;
    logic [DIM_W-1:0]   w_q;
    logic [DIM_W-1:0]   ox;
    logic [DIM_W-1:0]   oy;
    logic [3:0]         tap;
    logic [1:0]         dx;
    logic [1:0]         dy;
    logic [RD_LAT:0]    pipe_vld;
    logic [3:0]         pipe_tap [RD_LAT+1];
    logic [11:0]        gsum;
    logic signed [10:0] gx;
    logic signed [10:0] gy;

    // Stage 0 is registered alongside read_H/read_W; the last stage lines up with data0.
    logic       take;
    logic [3:0] tap_out;
    assign take    = pipe_vld[RD_LAT];
    assign tap_out = pipe_tap[RD_LAT];

    function automatic logic [11:0] gauss_term(input logic [3:0] t, input logic [7:0] p);
        case (t)
            4'd4:                   return {2'b00, p, 2'b00};
            4'd1, 4'd3, 4'd5, 4'd7: return {3'b000, p, 1'b0};
            default:                return {4'b0000, p};
        endcase
    endfunction

    function automatic logic [2:0] gx_coef(input logic [3:0] t);
        case (t)
            4'd0, 4'd6: return 3'b111;
            4'd3:       return 3'b110;
            4'd2, 4'd8: return 3'b001;
            4'd5:       return 3'b010;
            default:    return 3'b000;
        endcase
    endfunction

    function automatic logic [2:0] gy_coef(input logic [3:0] t);
        case (t)
            4'd0, 4'd2: return 3'b111;
            4'd1:       return 3'b110;
            4'd6, 4'd8: return 3'b001;
            4'd7:       return 3'b010;
            default:    return 3'b000;
        endcase
    endfunction

    function automatic logic signed [10:0] wterm(input logic [2:0] c, input logic [7:0] p);
        logic signed [10:0] v;
        v = $signed({3'b000, p});
        case (c)
            3'b001:  return v;
            3'b010:  return v <<< 1;
            3'b111:  return -v;
            3'b110:  return -(v <<< 1);
            default: return '0;
        endcase
    endfunction

    logic [10:0] ax;
    logic [10:0] ay;
    logic [11:0] mag;
    logic [7:0]  sobel_pix;
    logic [7:0]  gauss_pix;
    logic [7:0]  result;

    always_comb begin
        ax        = gx[10] ? $unsigned(-gx) : $unsigned(gx);
        ay        = gy[10] ? $unsigned(-gy) : $unsigned(gy);
        mag       = {1'b0, ax} + {1'b0, ay};
        sobel_pix = (mag > 12'd255) ? 8'd255 : mag[7:0];
        gauss_pix = 8'(gsum >> 4);
        result    = mode_q ? sobel_pix : gauss_pix;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            mode_q        <= 1'b0;
            h_q           <= '0;
            w_q           <= '0;
            ox            <= '0;
            oy            <= '0;
            tap           <= '0;
            dx            <= '0;
            dy            <= '0;
            pipe_vld      <= '0;
            for (int i = 0; i <= RD_LAT; i++) pipe_tap[i] <= '0;
            gsum          <= '0;
            gx            <= '0;
            gy            <= '0;
            read_H        <= '0;
            read_W        <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pix.pix_out   <= '0;
            pix.out_x     <= '0;
            pix.out_y     <= '0;
            pix.pix_valid <= 1'b0;
        end else begin
            pipe_vld <= {pipe_vld[RD_LAT-1:0], 1'b0};
            for (int i = 1; i <= RD_LAT; i++) pipe_tap[i] <= pipe_tap[i-1];

            if (take) begin
                gsum <= gsum + gauss_term(tap_out, data0);
                gx   <= gx + wterm(gx_coef(tap_out), data0);
                gy   <= gy + wterm(gy_coef(tap_out), data0);
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (start && all_loaded) begin
                        mode_q <= mode;
                        h_q    <= H;
                        w_q    <= W;
                        ox     <= '0;
                        oy     <= '0;
                        tap    <= '0;
                        dx     <= '0;
                        dy     <= '0;
                        gsum   <= '0;
                        gx     <= '0;
                        gy     <= '0;
                        if (H < DIM_W'(3) || W < DIM_W'(3)) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_ISSUE;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                        end
                    end
                end
                S_ISSUE: begin
                    read_H      <= oy + DIM_W'(dy);
                    read_W      <= ox + DIM_W'(dx);
                    pipe_vld[0] <= 1'b1;
                    pipe_tap[0] <= tap;
                    tap         <= tap + 4'd1;
                    if (dx == 2'd2) begin
                        dx <= 2'd0;
                        dy <= dy + 2'd1;
                    end else begin
                        dx <= dx + 2'd1;
                    end
                    if (tap == 4'd8) state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (pipe_vld == '0) begin
                        pix.pix_out   <= result;
                        pix.out_x     <= ox;
                        pix.out_y     <= oy;
                        pix.pix_valid <= 1'b1;
                        state         <= S_OUTPUT;
                    end
                end
                S_OUTPUT: begin
                    if (pix.pix_ready) begin
                        pix.pix_valid <= 1'b0;
                        tap           <= '0;
                        dx            <= '0;
                        dy            <= '0;
                        gsum          <= '0;
                        gx            <= '0;
                        gy            <= '0;
                        if (ox == w_q - DIM_W'(3)) begin
                            ox <= '0;
                            if (oy == h_q - DIM_W'(3)) begin
                                state <= S_DONE;
                                done  <= 1'b1;
                                busy  <= 1'b0;
                            end else begin
                                oy    <= oy + DIM_W'(1);
                                state <= S_ISSUE;
                            end
                        end else begin
                            ox    <= ox + DIM_W'(1);
                            state <= S_ISSUE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
